// File: rtl/dm_port_arbiter_if.sv
// Requester, response and memory-side signals of the data-memory port arbiter.
// master = requesters + memory model side, slave = arbiter side.
interface dm_port_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic [3:0]  be0;
  logic [3:0]  be1;
  logic        done0;
  logic        done1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic        err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, be0, be1,
    output mem_ready, mem_rdata,
    input  done0, done1, rdata0, rdata1, err,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, be0, be1,
    input  mem_ready, mem_rdata,
    output done0, done1, rdata0, rdata1, err,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing one byte-enabled DM port (port 0 = MEM stage, port 1 = bus bridge); mem_en 1 cycle after
// grant, done 1 cycle after mem_ready, requesters wait by holding req. DM_TIMEOUT_EN aborts a BUSY stalled TIMEOUT_CYCLES.
module dm_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  dm_port_arbiter_if.slave io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_ptr;
  logic        r_owner;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  logic        w_busy;
  logic        w_resp;
  logic        w_grant;
  logic        w_grant_id;
  logic        w_complete;
  logic        w_timeout;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_be;

  assign w_busy = (r_state == ST_BUSY);
  assign w_resp = (r_state == ST_RESP);

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_id  = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.req0 || io_bus.req1) begin
          w_grant     = 1'b1;
          // The pointer only breaks ties; a lone requester always wins.
          w_grant_id  = (io_bus.req0 && io_bus.req1) ? r_ptr : io_bus.req1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (io_bus.mem_ready) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_timeout) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_sel_we    = w_grant_id ? io_bus.we1    : io_bus.we0;
  assign w_sel_addr  = w_grant_id ? io_bus.addr1  : io_bus.addr0;
  assign w_sel_wdata = w_grant_id ? io_bus.wdata1 : io_bus.wdata0;
  assign w_sel_be    = w_grant_id ? io_bus.be1    : io_bus.be0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_grant) begin
      r_owner <= w_grant_id;
      r_we    <= w_sel_we;
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
      r_be    <= w_sel_be;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr <= 1'b0;
    end else if (w_complete || w_timeout) begin
      r_ptr <= ~r_owner;
    end
  end

  // Store completions leave the owner's read data untouched; aborts clear it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (w_timeout) begin
      if (r_owner) r_rdata1 <= '0;
      else         r_rdata0 <= '0;
    end else if (w_complete && !r_we) begin
      if (r_owner) r_rdata1 <= io_bus.mem_rdata;
      else         r_rdata0 <= io_bus.mem_rdata;
    end
  end

`ifdef DM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  assign w_timeout = w_busy && !io_bus.mem_ready && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_grant) begin
        r_cnt <= '0;
      end else if (w_busy && !io_bus.mem_ready) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (w_complete) begin
        r_err <= 1'b0;
      end
    end
  end

  assign io_bus.err = w_resp && r_err;
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
  assign io_bus.err       = 1'b0;
`endif

  assign io_bus.done0     = w_resp && !r_owner;
  assign io_bus.done1     = w_resp && r_owner;
  assign io_bus.rdata0    = r_rdata0;
  assign io_bus.rdata1    = r_rdata1;
  assign io_bus.mem_en    = w_busy;
  assign io_bus.mem_we    = w_busy && r_we;
  assign io_bus.mem_addr  = r_addr;
  assign io_bus.mem_wdata = r_wdata;
  assign io_bus.mem_be    = (w_busy && r_we) ? r_be : 4'b0000;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed scenarios plus randomized transactions against a transaction-level model.
module tb_dm_port_arbiter;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  logic        p_req[2];
  logic        p_we[2];
  logic [31:0] p_addr[2];
  logic [31:0] p_wdata[2];
  logic [3:0]  p_be[2];

  dm_port_arbiter_if bus();

  dm_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.be0 = '0; bus.be1 = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic drive_ports();
    bus.req0 = p_req[0]; bus.we0 = p_we[0]; bus.addr0 = p_addr[0];
    bus.wdata0 = p_wdata[0]; bus.be0 = p_be[0];
    bus.req1 = p_req[1]; bus.we1 = p_we[1]; bus.addr1 = p_addr[1];
    bus.wdata1 = p_wdata[1]; bus.be1 = p_be[1];
  endtask

  task automatic new_payload(input int p);
    p_we[p]    = 1'($urandom_range(0, 1));
    p_addr[p]  = $urandom;
    p_wdata[p] = $urandom;
    p_be[p]    = 4'($urandom_range(0, 15));
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if ({bus.done0, bus.done1, bus.err, bus.mem_en, bus.mem_we, bus.mem_be} !== 9'h0) begin
      n_err++; $display("FAIL reset_ctrl: got %h want 0", {bus.done0, bus.done1, bus.err, bus.mem_en, bus.mem_we, bus.mem_be}); end
    n_cmp++; if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
      n_err++; $display("FAIL reset_mem_bus: got %h want 0", {bus.mem_addr, bus.mem_wdata}); end
    n_cmp++; if ({bus.rdata0, bus.rdata1} !== 64'h0) begin
      n_err++; $display("FAIL reset_rdata: got %h want 0", {bus.rdata0, bus.rdata1}); end
    reset = 1'b0;
    tick();
    n_cmp++; if ({bus.done0, bus.done1, bus.mem_en} !== 3'b000) begin
      n_err++; $display("FAIL reset_idle: got %b want 000", {bus.done0, bus.done1, bus.mem_en}); end
  endtask

  task automatic test_single_store();
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h0000_0006;
    bus.be0 = 4'b0100; bus.wdata0 = 32'h00AB_0000; bus.mem_ready = 1'b1;
    n_cmp++; if (bus.mem_en !== 1'b0) begin n_err++; $display("FAIL store_c0_en: got %b want 0", bus.mem_en); end
    tick();
    n_cmp++; if ({bus.mem_en, bus.mem_we, bus.mem_be} !== 6'b11_0100) begin
      n_err++; $display("FAIL store_c1_ctrl: got %b want 110100", {bus.mem_en, bus.mem_we, bus.mem_be}); end
    n_cmp++; if ({bus.mem_addr, bus.mem_wdata} !== {32'h6, 32'h00AB_0000}) begin
      n_err++; $display("FAIL store_c1_bus: got %h want %h", {bus.mem_addr, bus.mem_wdata}, {32'h6, 32'h00AB_0000}); end
    tick();
    n_cmp++; if ({bus.done0, bus.done1, bus.err, bus.mem_en, bus.mem_be} !== 8'b1000_0000) begin
      n_err++; $display("FAIL store_c2: got %b want 10000000", {bus.done0, bus.done1, bus.err, bus.mem_en, bus.mem_be}); end
    n_cmp++; if (bus.mem_addr !== 32'h6) begin n_err++; $display("FAIL store_addr_hold: got %h want 6", bus.mem_addr); end
    bus.req0 = 1'b0;
    tick();
    n_cmp++; if ({bus.done0, bus.done1} !== 2'b00) begin
      n_err++; $display("FAIL store_c3_done: got %b want 00", {bus.done0, bus.done1}); end
  endtask

  task automatic test_load_wait();
    do_reset();
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h0000_0100;
    bus.be1 = 4'b1111; bus.wdata1 = 32'h1234_5678; bus.mem_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_cmp++; if ({bus.mem_en, bus.mem_we, bus.mem_be, bus.done1} !== 7'b10_0000_0) begin
        n_err++; $display("FAIL load_busy_c%0d: got %b want 1000000", c, {bus.mem_en, bus.mem_we, bus.mem_be, bus.done1}); end
    end
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
    n_cmp++; if ({bus.done1, bus.done0, bus.err, bus.mem_en} !== 4'b1000) begin
      n_err++; $display("FAIL load_done: got %b want 1000", {bus.done1, bus.done0, bus.err, bus.mem_en}); end
    n_cmp++; if (bus.rdata1 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_rdata1: got %h want deadbeef", bus.rdata1); end
    bus.req1 = 1'b0;
    tick();
    n_cmp++; if ({bus.done1, bus.rdata1} !== {1'b0, 32'hDEAD_BEEF}) begin
      n_err++; $display("FAIL load_hold: got %h want %h", {bus.done1, bus.rdata1}, {1'b0, 32'hDEAD_BEEF}); end
  endtask

  task automatic test_contention();
    int   owner;
    logic e0;
    logic e1;
    do_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.addr0 = 32'h1000; bus.addr1 = 32'h2000;
    bus.mem_ready = 1'b1;
    // Transaction k occupies cycles 3k+1 (BUSY) and 3k+2 (done); owners alternate from port 0.
    for (int c = 1; c <= 12; c++) begin
      tick();
      owner = ((c - 1) / 3) % 2;
      e0 = (c % 3 == 2) && (owner == 0);
      e1 = (c % 3 == 2) && (owner == 1);
      n_cmp++; if ({bus.done0, bus.done1} !== {e0, e1}) begin
        n_err++; $display("FAIL contend_done_c%0d: got %b want %b", c, {bus.done0, bus.done1}, {e0, e1}); end
      if (c % 3 == 1) begin
        n_cmp++; if ({bus.mem_en, bus.mem_addr} !== {1'b1, (owner == 1) ? 32'h2000 : 32'h1000}) begin
          n_err++; $display("FAIL contend_grant_c%0d: got %h want owner %0d", c, {bus.mem_en, bus.mem_addr}, owner); end
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'hA0; bus.mem_ready = 1'b1;
    tick();
    tick();
    bus.req0 = 1'b0; bus.mem_ready = 1'b0;
    tick();
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'hB0; bus.be1 = 4'hF; bus.wdata1 = 32'h5555_5555;
    tick();
    n_cmp++; if (bus.mem_en !== 1'b1) begin n_err++; $display("FAIL midrst_busy: got %b want 1", bus.mem_en); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({bus.mem_en, bus.mem_we, bus.mem_be, bus.done1} !== 7'b0) begin
      n_err++; $display("FAIL midrst_async: got %b want 0000000", {bus.mem_en, bus.mem_we, bus.mem_be, bus.done1}); end
    bus.req1 = 1'b0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if ({bus.done0, bus.done1} !== 2'b00) begin
        n_err++; $display("FAIL midrst_nodone_%0d: got %b want 00", c, {bus.done0, bus.done1}); end
    end
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.we0 = 1'b0; bus.we1 = 1'b0; bus.mem_ready = 1'b1;
    tick();
    n_cmp++; if (bus.mem_addr !== 32'hA0) begin n_err++; $display("FAIL midrst_ptr: got %h want a0", bus.mem_addr); end
    tick();
    n_cmp++; if ({bus.done0, bus.done1} !== 2'b10) begin
      n_err++; $display("FAIL midrst_first_done: got %b want 10", {bus.done0, bus.done1}); end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
  endtask

  task automatic test_zero_mask();
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h40; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234_5678;
    tick();
    tick();
    n_cmp++; if (bus.rdata0 !== 32'h1234_5678) begin n_err++; $display("FAIL zm_preload: got %h want 12345678", bus.rdata0); end
    bus.req0 = 1'b0;
    tick();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.be0 = 4'b0000; bus.addr0 = 32'h44;
    bus.wdata0 = 32'hFFFF_FFFF; bus.mem_rdata = 32'hBAD0_BAD0;
    tick();
    n_cmp++; if ({bus.mem_en, bus.mem_we, bus.mem_be} !== 6'b11_0000) begin
      n_err++; $display("FAIL zm_issue: got %b want 110000", {bus.mem_en, bus.mem_we, bus.mem_be}); end
    tick();
    n_cmp++; if ({bus.done0, bus.rdata0} !== {1'b1, 32'h1234_5678}) begin
      n_err++; $display("FAIL zm_done: got %h want %h", {bus.done0, bus.rdata0}, {1'b1, 32'h1234_5678}); end
    bus.req0 = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int seen;
    seen = 0;
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h70; bus.mem_ready = 1'b1; bus.mem_rdata = 32'hA5A5_A5A5;
    tick();
    tick();
    bus.req0 = 1'b0;
    tick();
    bus.req0 = 1'b1; bus.addr0 = 32'h80; bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
    tick();
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h90;
    for (int c = 2; c <= 4; c++) begin
      tick();
      n_cmp++; if ({bus.mem_en, bus.done0} !== 2'b10) begin
        n_err++; $display("FAIL to_stall_c%0d: got %b want 10", c, {bus.mem_en, bus.done0}); end
    end
`ifdef DM_TIMEOUT_EN
    tick();
    n_cmp++; if ({bus.done0, bus.done1, bus.err, bus.rdata0} !== {3'b101, 32'h0}) begin
      n_err++; $display("FAIL to_abort: got %h want %h", {bus.done0, bus.done1, bus.err, bus.rdata0}, {3'b101, 32'h0}); end
    bus.req0 = 1'b0;
    tick();
    tick();
    n_cmp++; if ({bus.mem_en, bus.mem_addr} !== {1'b1, 32'h90}) begin
      n_err++; $display("FAIL to_next_grant: got %h want %h", {bus.mem_en, bus.mem_addr}, {1'b1, 32'h90}); end
    bus.mem_ready = 1'b1;
    tick();
    n_cmp++; if ({bus.done1, bus.err} !== 2'b10) begin
      n_err++; $display("FAIL to_normal_err: got %b want 10", {bus.done1, bus.err}); end
    bus.req1 = 1'b0; bus.mem_ready = 1'b0;
    tick();
`else
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.done0 || bus.err) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL to_never_done: got %0d want 0", seen); end
    n_cmp++; if (bus.mem_en !== 1'b1) begin n_err++; $display("FAIL to_still_busy: got %b want 1", bus.mem_en); end
    do_reset();
`endif
  endtask

  task automatic test_random();
    int          o;
    int          m_ptr;
    int          stalls;
    logic [31:0] m_rd[2];
    logic [31:0] last_rd;
    do_reset();
    m_ptr = 0; m_rd[0] = '0; m_rd[1] = '0; last_rd = '0;
    p_req[0] = 1'b0; p_req[1] = 1'b0;
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!p_req[p] && ($urandom_range(0, 2) != 0)) begin
          p_req[p] = 1'b1;
          new_payload(p);
        end
      end
      if (!p_req[0] && !p_req[1]) begin
        p_req[0] = 1'b1;
        new_payload(0);
      end
      drive_ports();
      bus.mem_ready = 1'($urandom_range(0, 1));
      o = (p_req[0] && p_req[1]) ? m_ptr : (p_req[1] ? 1 : 0);
      stalls = $urandom_range(0, 3);
      tick();
      n_cmp++; if ({bus.mem_en, bus.mem_we, bus.mem_be} !== {1'b1, p_we[o], p_we[o] ? p_be[o] : 4'h0}) begin
        n_err++; $display("FAIL rnd_ctrl_%0d: got %b want owner %0d we %b be %b", it, {bus.mem_en, bus.mem_we, bus.mem_be}, o, p_we[o], p_be[o]); end
      n_cmp++; if ({bus.mem_addr, bus.mem_wdata} !== {p_addr[o], p_wdata[o]}) begin
        n_err++; $display("FAIL rnd_bus_%0d: got %h want %h", it, {bus.mem_addr, bus.mem_wdata}, {p_addr[o], p_wdata[o]}); end
      for (int s = 0; s <= stalls; s++) begin
        bus.mem_ready = (s == stalls);
        bus.mem_rdata = $urandom;
        last_rd = bus.mem_rdata;
        tick();
        if (s < stalls) begin
          n_cmp++; if ({bus.mem_en, bus.done0, bus.done1} !== 3'b100) begin
            n_err++; $display("FAIL rnd_wait_%0d: got %b want 100", it, {bus.mem_en, bus.done0, bus.done1}); end
        end
      end
      if (!p_we[o]) m_rd[o] = last_rd;
      m_ptr = 1 - o;
      n_cmp++; if ({bus.done0, bus.done1, bus.err, bus.mem_en} !== {o == 0, o == 1, 2'b00}) begin
        n_err++; $display("FAIL rnd_done_%0d: got %b want owner %0d", it, {bus.done0, bus.done1, bus.err, bus.mem_en}, o); end
      n_cmp++; if ({bus.rdata0, bus.rdata1} !== {m_rd[0], m_rd[1]}) begin
        n_err++; $display("FAIL rnd_rdata_%0d: got %h want %h", it, {bus.rdata0, bus.rdata1}, {m_rd[0], m_rd[1]}); end
      p_req[o] = 1'b0;
      drive_ports();
      bus.mem_ready = 1'($urandom_range(0, 1));
      tick();
      n_cmp++; if ({bus.done0, bus.done1, bus.mem_en} !== 3'b000) begin
        n_err++; $display("FAIL rnd_idle_%0d: got %b want 000", it, {bus.done0, bus.done1, bus.mem_en}); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_store();
    test_load_wait();
    test_contention();
    test_reset_mid_op();
    test_zero_mask();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
